execute: RTL and testbench

Execute stage of the ECE369 pipelined MIPS-subset datapath, between ID/EX and EX/MEM. Selects ALU operands from register data, shamt and immediate, decodes opcode/funct into an ALU operation, and computes the ALU result and Zero flag. Also forms the branch target, the shifted jump index and the destination register number. All outputs are registered, so the block also acts as the EX/MEM boundary for these signals.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/alu32.sv | 35 +++
 rtl/execute.sv | 98 +++++++++
 tb/tb_execute.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and ALU operation encoding for the MIPS-subset datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MUL, ALU_PASSA, ALU_ZERO
    } alu_op_t;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; shift amounts come from a[4:0], zero flags an all-zero result.
module alu32
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL:   result = b << a[4:0];
            ALU_SRL:   result = b >> a[4:0];
            ALU_SRA:   result = $unsigned($signed(b) >>> a[4:0]);
            ALU_LUI:   result = {b[15:0], 16'h0000};
            // low half of the product is identical for signed and unsigned operands
            ALU_MUL:   result = a * b;
            ALU_PASSA: result = a;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// EX stage: operand muxes, ALU decode, branch target, jump shift and destination select,
// all captured in the EX/MEM output registers.
module execute
    import mips_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegDst,
    input  logic        ALUSrc0,
    input  logic        ALUSrc1,
    input  logic [4:0]  Shamt,
    input  logic [31:0] Reg_Data1,
    input  logic [31:0] Reg_Data2,
    input  logic [31:0] Imm32b,
    input  logic [31:0] PCPlusFour,
    input  logic [5:0]  Instruction,
    input  logic [5:0]  Opcode,
    input  logic [25:0] instr_index,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic        Zero_output,
    output logic [31:0] ALUResult_output,
    output logic [27:0] j_sll_two_output,
    output logic [31:0] PC_Plus_Branch_output,
    output logic [4:0]  RegDestSelected_output
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] branch_target;
    logic [4:0]  dest_reg;
    alu_op_t     alu_op;

    assign op_a          = ALUSrc0 ? {27'b0, Shamt} : Reg_Data1;
    assign op_b          = ALUSrc1 ? Reg_Data2 : Imm32b;
    assign branch_target = PCPlusFour + {Imm32b[29:0], 2'b00};
    assign dest_reg      = RegDst ? rt : rd;

    always_comb begin
        alu_op = ALU_ZERO;
        case (Opcode)
            OP_RTYPE: begin
                case (Instruction)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:          alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLL, FN_SLLV: alu_op = ALU_SLL;
                    FN_SRL, FN_SRLV: alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_JR:           alu_op = ALU_PASSA;
                    default:         alu_op = ALU_ZERO;
                endcase
            end
            OP_SPECIAL2: alu_op = (Instruction == FN_MUL) ? ALU_MUL : ALU_ZERO;
            OP_ADDI, OP_ADDIU,
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: alu_op = ALU_ADD;
            OP_ANDI:         alu_op = ALU_AND;
            OP_ORI:          alu_op = ALU_OR;
            OP_XORI:         alu_op = ALU_XOR;
            OP_SLTI:         alu_op = ALU_SLT;
            OP_LUI:          alu_op = ALU_LUI;
            // bne sense is inverted downstream; both branches just compare via subtraction
            OP_BEQ, OP_BNE:  alu_op = ALU_SUB;
            default:         alu_op = ALU_ZERO;
        endcase
    end

    alu32 u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Zero_output            <= 1'b0;
            ALUResult_output       <= '0;
            j_sll_two_output       <= '0;
            PC_Plus_Branch_output  <= '0;
            RegDestSelected_output <= '0;
        end else begin
            Zero_output            <= alu_zero;
            ALUResult_output       <= alu_result;
            j_sll_two_output       <= {instr_index, 2'b00};
            PC_Plus_Branch_output  <= branch_target;
            RegDestSelected_output <= dest_reg;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
module tb_execute;

    logic        Clk;
    logic        Reset;
    logic        RegDst;
    logic        ALUSrc0;
    logic        ALUSrc1;
    logic [4:0]  Shamt;
    logic [31:0] Reg_Data1;
    logic [31:0] Reg_Data2;
    logic [31:0] Imm32b;
    logic [31:0] PCPlusFour;
    logic [5:0]  Instruction;
    logic [5:0]  Opcode;
    logic [25:0] instr_index;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        Zero_output;
    logic [31:0] ALUResult_output;
    logic [27:0] j_sll_two_output;
    logic [31:0] PC_Plus_Branch_output;
    logic [4:0]  RegDestSelected_output;

    int checks = 0;
    int errors = 0;

    execute dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .RegDst                 (RegDst),
        .ALUSrc0                (ALUSrc0),
        .ALUSrc1                (ALUSrc1),
        .Shamt                  (Shamt),
        .Reg_Data1              (Reg_Data1),
        .Reg_Data2              (Reg_Data2),
        .Imm32b                 (Imm32b),
        .PCPlusFour             (PCPlusFour),
        .Instruction            (Instruction),
        .Opcode                 (Opcode),
        .instr_index            (instr_index),
        .rt                     (rt),
        .rd                     (rd),
        .Zero_output            (Zero_output),
        .ALUResult_output       (ALUResult_output),
        .j_sll_two_output       (j_sll_two_output),
        .PC_Plus_Branch_output  (PC_Plus_Branch_output),
        .RegDestSelected_output (RegDestSelected_output)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic set_defaults();
        RegDst = 0; ALUSrc0 = 0; ALUSrc1 = 1; Shamt = 0;
        Reg_Data1 = 0; Reg_Data2 = 0; Imm32b = 0; PCPlusFour = 0;
        Instruction = 0; Opcode = 0; instr_index = 0; rt = 0; rd = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        set_defaults();
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #2;
        checks++; if (ALUResult_output !== 32'd0) begin errors++; $display("FAIL reset_result got %h expected %h", ALUResult_output, 32'd0); end
        checks++; if (Zero_output !== 1'b0) begin errors++; $display("FAIL reset_zero got %b expected 0", Zero_output); end
        checks++; if (j_sll_two_output !== 28'd0) begin errors++; $display("FAIL reset_jump got %h expected 0", j_sll_two_output); end
        checks++; if (PC_Plus_Branch_output !== 32'd0) begin errors++; $display("FAIL reset_branch got %h expected 0", PC_Plus_Branch_output); end
        checks++; if (RegDestSelected_output !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d expected 0", RegDestSelected_output); end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_rtype();
        set_defaults();
        Instruction = 6'h20; Reg_Data1 = 5; Reg_Data2 = 7; rd = 16; rt = 12;
        step();
        checks++; if (ALUResult_output !== 32'd12) begin errors++; $display("FAIL add_result got %h expected %h", ALUResult_output, 32'd12); end
        checks++; if (Zero_output !== 1'b0) begin errors++; $display("FAIL add_zero got %b expected 0", Zero_output); end
        checks++; if (RegDestSelected_output !== 5'd16) begin errors++; $display("FAIL add_dest got %0d expected 16", RegDestSelected_output); end

        Instruction = 6'h22; Reg_Data1 = 32'h55; Reg_Data2 = 32'h55;
        step();
        checks++; if (ALUResult_output !== 32'd0 || Zero_output !== 1'b1) begin errors++; $display("FAIL sub_equal got %h/%b expected 0/1", ALUResult_output, Zero_output); end

        Instruction = 6'h2A; Reg_Data1 = 32'hFFFFFFFF; Reg_Data2 = 32'd1;
        step();
        checks++; if (ALUResult_output !== 32'd1) begin errors++; $display("FAIL slt_signed got %h expected 1", ALUResult_output); end

        Instruction = 6'h27; Reg_Data1 = 32'h0F0F0000; Reg_Data2 = 32'h000000F0;
        step();
        checks++; if (ALUResult_output !== 32'hF0F0FF0F) begin errors++; $display("FAIL nor got %h expected F0F0FF0F", ALUResult_output); end

        Instruction = 6'h26; Reg_Data1 = 32'hFF00FF00; Reg_Data2 = 32'h0FF00FF0;
        step();
        checks++; if (ALUResult_output !== 32'hF0F0F0F0) begin errors++; $display("FAIL xor got %h expected F0F0F0F0", ALUResult_output); end

        Instruction = 6'h08; Reg_Data1 = 32'h00400020; Reg_Data2 = 32'h12345678;
        step();
        checks++; if (ALUResult_output !== 32'h00400020) begin errors++; $display("FAIL jr_pass got %h expected 00400020", ALUResult_output); end

        Opcode = 6'h1C; Instruction = 6'h02; Reg_Data1 = 32'hFFFFFFFD; Reg_Data2 = 32'd5;
        step();
        checks++; if (ALUResult_output !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul got %h expected FFFFFFF1", ALUResult_output); end

        Opcode = 6'h00; Instruction = 6'h3F; Reg_Data1 = 32'd9; Reg_Data2 = 32'd9;
        step();
        checks++; if (ALUResult_output !== 32'd0 || Zero_output !== 1'b1) begin errors++; $display("FAIL undef_funct got %h/%b expected 0/1", ALUResult_output, Zero_output); end
    endtask

    task automatic test_branch();
        set_defaults();
        Opcode = 6'h04; Reg_Data1 = 32'h1234; Reg_Data2 = 32'h1234;
        PCPlusFour = 32'h100; Imm32b = 32'hFFFFFFFF;
        step();
        checks++; if (Zero_output !== 1'b1) begin errors++; $display("FAIL beq_zero got %b expected 1", Zero_output); end
        checks++; if (PC_Plus_Branch_output !== 32'hFC) begin errors++; $display("FAIL beq_target got %h expected 000000FC", PC_Plus_Branch_output); end

        Opcode = 6'h05; Reg_Data1 = 32'h10; Reg_Data2 = 32'h3; PCPlusFour = 32'h200; Imm32b = 32'd4;
        step();
        checks++; if (ALUResult_output !== 32'hD || Zero_output !== 1'b0) begin errors++; $display("FAIL bne_sub got %h/%b expected D/0", ALUResult_output, Zero_output); end
        checks++; if (PC_Plus_Branch_output !== 32'h210) begin errors++; $display("FAIL bne_target got %h expected 00000210", PC_Plus_Branch_output); end

        PCPlusFour = 32'hFFFFFFF0; Imm32b = 32'h40000008;
        step();
        checks++; if (PC_Plus_Branch_output !== 32'h00000010) begin errors++; $display("FAIL branch_wrap got %h expected 00000010", PC_Plus_Branch_output); end
    endtask

    task automatic test_shift();
        set_defaults();
        Instruction = 6'h00; ALUSrc0 = 1; Shamt = 4; Reg_Data1 = 32'hFFFFFFFF; Reg_Data2 = 32'hF;
        step();
        checks++; if (ALUResult_output !== 32'hF0) begin errors++; $display("FAIL sll got %h expected F0", ALUResult_output); end

        Instruction = 6'h03; Shamt = 31; Reg_Data2 = 32'h80000000;
        step();
        checks++; if (ALUResult_output !== 32'hFFFFFFFF) begin errors++; $display("FAIL sra got %h expected FFFFFFFF", ALUResult_output); end

        Instruction = 6'h02;
        step();
        checks++; if (ALUResult_output !== 32'd1) begin errors++; $display("FAIL srl got %h expected 1", ALUResult_output); end

        Instruction = 6'h06; ALUSrc0 = 0; Reg_Data1 = 32'd4; Reg_Data2 = 32'h100;
        step();
        checks++; if (ALUResult_output !== 32'h10) begin errors++; $display("FAIL srlv got %h expected 10", ALUResult_output); end

        Instruction = 6'h04; Reg_Data1 = 32'd36; Reg_Data2 = 32'h3;
        step();
        checks++; if (ALUResult_output !== 32'h30) begin errors++; $display("FAIL sllv_mask got %h expected 30", ALUResult_output); end
    endtask

    task automatic test_itype();
        set_defaults();
        ALUSrc1 = 0; RegDst = 1; rt = 9; rd = 3;
        Opcode = 6'h0F; Imm32b = 32'h0000ABCD; Reg_Data2 = 32'h11111111;
        step();
        checks++; if (ALUResult_output !== 32'hABCD0000) begin errors++; $display("FAIL lui got %h expected ABCD0000", ALUResult_output); end
        checks++; if (RegDestSelected_output !== 5'd9) begin errors++; $display("FAIL lui_dest got %0d expected 9", RegDestSelected_output); end

        Opcode = 6'h0A; Reg_Data1 = 32'hFFFFFFFD; Imm32b = 32'd2;
        step();
        checks++; if (ALUResult_output !== 32'd1) begin errors++; $display("FAIL slti got %h expected 1", ALUResult_output); end

        Opcode = 6'h0D; Reg_Data1 = 32'h12340000; Imm32b = 32'h00005678;
        step();
        checks++; if (ALUResult_output !== 32'h12345678) begin errors++; $display("FAIL ori got %h expected 12345678", ALUResult_output); end

        Opcode = 6'h23; Reg_Data1 = 32'h1000; Imm32b = 32'hFFFFFFFC;
        step();
        checks++; if (ALUResult_output !== 32'h00000FFC) begin errors++; $display("FAIL lw_addr got %h expected 00000FFC", ALUResult_output); end

        Opcode = 6'h08; Reg_Data1 = 32'hFFFFFFFF; Imm32b = 32'd1;
        step();
        checks++; if (ALUResult_output !== 32'd0 || Zero_output !== 1'b1) begin errors++; $display("FAIL addi_wrap got %h/%b expected 0/1", ALUResult_output, Zero_output); end
    endtask

    task automatic test_jump();
        set_defaults();
        Opcode = 6'h02; instr_index = 26'h3FFFFFF; Reg_Data1 = 32'd7; Reg_Data2 = 32'd8;
        step();
        checks++; if (j_sll_two_output !== 28'hFFFFFFC) begin errors++; $display("FAIL j_shift got %h expected FFFFFFC", j_sll_two_output); end
        checks++; if (ALUResult_output !== 32'd0 || Zero_output !== 1'b1) begin errors++; $display("FAIL j_result got %h/%b expected 0/1", ALUResult_output, Zero_output); end
    endtask

    task automatic test_reset_mid();
        set_defaults();
        Instruction = 6'h20; Reg_Data1 = 5; Reg_Data2 = 7; rd = 16; instr_index = 26'h1; PCPlusFour = 32'h40;
        step();
        checks++; if (ALUResult_output !== 32'd12) begin errors++; $display("FAIL pre_reset got %h expected C", ALUResult_output); end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++; if (ALUResult_output !== 32'd0 || RegDestSelected_output !== 5'd0 || j_sll_two_output !== 28'd0 || PC_Plus_Branch_output !== 32'd0) begin
            errors++; $display("FAIL async_reset got %h/%0d/%h/%h expected all 0", ALUResult_output, RegDestSelected_output, j_sll_two_output, PC_Plus_Branch_output);
        end
        step();
        checks++; if (ALUResult_output !== 32'd0 || PC_Plus_Branch_output !== 32'd0) begin errors++; $display("FAIL reset_hold got %h/%h expected 0/0", ALUResult_output, PC_Plus_Branch_output); end
        @(negedge Clk);
        Reset = 1'b1;
        step();
        checks++; if (ALUResult_output !== 32'd12 || j_sll_two_output !== 28'h4 || PC_Plus_Branch_output !== 32'h40) begin
            errors++; $display("FAIL post_reset got %h/%h/%h expected C/4/40", ALUResult_output, j_sll_two_output, PC_Plus_Branch_output);
        end
    endtask

    task automatic test_back_to_back();
        set_defaults();
        Instruction = 6'h24; Reg_Data1 = 32'hFF00FF00; Reg_Data2 = 32'h0FF00FF0; rd = 5;
        step();
        checks++; if (ALUResult_output !== 32'h0F000F00 || RegDestSelected_output !== 5'd5) begin errors++; $display("FAIL b2b_and got %h/%0d expected 0F000F00/5", ALUResult_output, RegDestSelected_output); end
        Instruction = 6'h25; rd = 6;
        step();
        checks++; if (ALUResult_output !== 32'hFFF0FFF0 || RegDestSelected_output !== 5'd6) begin errors++; $display("FAIL b2b_or got %h/%0d expected FFF0FFF0/6", ALUResult_output, RegDestSelected_output); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_shift();
        test_itype();
        test_jump();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
